// File: rtl/mulpop_pkg.sv
// Shared definitions for the multiply/popcount scheduler slice: FSM states,
// field widths, the response payload struct, GPIO-visible datapath register
// addresses and a small pointer helper.
package mulpop_pkg;

  localparam int unsigned OPW   = 24;  // operand width
  localparam int unsigned RESW  = 32;  // product low word width
  localparam int unsigned ONESW = 6;   // set-bit count width (0..32)
  localparam int unsigned IDW   = 3;   // requester index width
  localparam int unsigned JCW   = 16;  // completed-job counter width
  localparam int unsigned ADDRW = 12;

  // Datapath register map, shared with the GPIO bus decoder
  localparam logic [ADDRW-1:0] ADDR_A1   = 12'h380;
  localparam logic [ADDRW-1:0] ADDR_A2   = 12'h388;
  localparam logic [ADDRW-1:0] ADDR_W    = 12'h390;
  localparam logic [ADDRW-1:0] ADDR_L    = 12'h398;
  localparam logic [ADDRW-1:0] ADDR_CTRL = 12'h3A0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [RESW-1:0]  w;
    logic [ONESW-1:0] ones;
    logic             ovf;
    logic             err;
  } rsp_t;

  // Increment a requester index modulo n
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v, input int unsigned n);
    if (32'(v) + 32'd1 >= n) return '0;
    return v + IDW'(1);
  endfunction

endpackage

// File: rtl/mulpop_sched_if.sv
// Bus bundle for mulpop_sched: requester job channel, datapath issue/complete
// channel and the shared tagged response channel.
//   master: scheduler side (accepts jobs, drives datapath, sources responses)
//   slave : environment side (requesters, datapath, response consumer)
interface mulpop_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned OPW  = mulpop_pkg::OPW
);

  logic [NREQ-1:0]                  req_valid;
  logic [NREQ-1:0]                  req_ready;
  logic [NREQ*OPW-1:0]              req_a1;
  logic [NREQ*OPW-1:0]              req_a2;

  logic                             dp_start;
  logic [OPW-1:0]                   dp_a1;
  logic [OPW-1:0]                   dp_a2;
  logic                             dp_done;
  logic [mulpop_pkg::RESW-1:0]      dp_w;
  logic [mulpop_pkg::ONESW-1:0]     dp_ones;
  logic                             dp_ovf;

  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [mulpop_pkg::IDW-1:0]       rsp_id;
  logic [mulpop_pkg::RESW-1:0]      rsp_w;
  logic [mulpop_pkg::ONESW-1:0]     rsp_ones;
  logic                             rsp_ovf;
  logic                             rsp_err;

  modport master (
    input  req_valid, req_a1, req_a2, dp_done, dp_w, dp_ones, dp_ovf, rsp_ready,
    output req_ready, dp_start, dp_a1, dp_a2,
           rsp_valid, rsp_id, rsp_w, rsp_ones, rsp_ovf, rsp_err
  );

  modport slave (
    output req_valid, req_a1, req_a2, dp_done, dp_w, dp_ones, dp_ovf, rsp_ready,
    input  req_ready, dp_start, dp_a1, dp_a2,
           rsp_valid, rsp_id, rsp_w, rsp_ones, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/mulpop_sched_rr_pick.sv
// rr_pick: combinational round-robin arbiter. Picks the first set request at
// or above ptr, wrapping past NREQ-1 back to 0.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   grant_c : one-hot grant
//   idx_c   : index of the granted requester
//   any_c   : at least one request present
module rr_pick
  import mulpop_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  idx_c,
  output logic            any_c
);

  // Winner is the requester with the smallest wrapped distance from ptr
  always_comb begin
    int unsigned best_off;
    int unsigned best_i;
    int unsigned off;
    best_off = NREQ;
    best_i   = 0;
    off      = 0;
    any_c    = 1'b0;
    grant_c  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      off = (i + NREQ - 32'(ptr)) % NREQ;
      if (req[i] && (off < best_off)) begin
        best_off = off;
        best_i   = i;
        any_c    = 1'b1;
      end
    end
    idx_c = IDW'(best_i);
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_c[i] = any_c && (best_i == i);
    end
  end

endmodule

// File: rtl/mulpop_sched.sv
// mulpop_sched: round-robin scheduler sharing one multiply/popcount datapath
// among NREQ requesters, one job in flight, with timeout abort.
//   clk, n_reset : clock, asynchronous active-low reset
//   bus          : requester / datapath / response channels (master modport)
//   busy         : high whenever the FSM is not idle
//   job_count    : completed responses, wrapping 16-bit counter
module mulpop_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned OPW     = mulpop_pkg::OPW,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      n_reset,
  mulpop_sched_if.master            bus,
  output logic                      busy,
  output logic [mulpop_pkg::JCW-1:0] job_count
);

  import mulpop_pkg::*;

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Expiry count chosen so the error response rises TIMEOUT cycles after dp_start
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [OPW-1:0]  dp_a1_q, dp_a1_d;
  logic [OPW-1:0]  dp_a2_q, dp_a2_d;
  logic            dp_start_q, dp_start_d;
  rsp_t            rsp_q, rsp_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            busy_q, busy_d;
  logic [JCW-1:0]  job_count_q, job_count_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [NREQ-1:0] grant_c;
  logic [IDW-1:0]  pick_idx_c;
  logic            pick_any_c;
  logic [OPW-1:0]  a1_sel_c, a2_sel_c;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .grant_c (grant_c),
    .idx_c   (pick_idx_c),
    .any_c   (pick_any_c)
  );

  // Operands of the granted requester
  always_comb begin
    a1_sel_c = '0;
    a2_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        a1_sel_c = bus.req_a1[i*OPW +: OPW];
        a2_sel_c = bus.req_a2[i*OPW +: OPW];
      end
    end
  end

  // Accept strobe only while idle; forced low while reset is held
  assign bus.req_ready = (n_reset && (state_q == S_IDLE)) ? grant_c : '0;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    dp_a1_d     = dp_a1_q;
    dp_a2_d     = dp_a2_q;
    dp_start_d  = 1'b0;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    job_count_d = job_count_q;
    tmo_d       = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (pick_any_c) begin
          dp_a1_d    = a1_sel_c;
          dp_a2_d    = a2_sel_c;
          rsp_d.id   = pick_idx_c;
          dp_start_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a simultaneous timeout
        if (bus.dp_done) begin
          rsp_d.w     = bus.dp_w;
          rsp_d.ones  = bus.dp_ones;
          rsp_d.ovf   = bus.dp_ovf;
          rsp_d.err   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_d.w     = '0;
          rsp_d.ones  = '0;
          rsp_d.ovf   = 1'b0;
          rsp_d.err   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = wrap_inc(rsp_q.id, NREQ);
          job_count_d = job_count_q + JCW'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      dp_a1_q     <= '0;
      dp_a2_q     <= '0;
      dp_start_q  <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      job_count_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      dp_a1_q     <= dp_a1_d;
      dp_a2_q     <= dp_a2_d;
      dp_start_q  <= dp_start_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      job_count_q <= job_count_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.dp_start  = dp_start_q;
  assign bus.dp_a1     = dp_a1_q;
  assign bus.dp_a2     = dp_a2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_w     = rsp_q.w;
  assign bus.rsp_ones  = rsp_q.ones;
  assign bus.rsp_ovf   = rsp_q.ovf;
  assign bus.rsp_err   = rsp_q.err;
  assign busy          = busy_q;
  assign job_count     = job_count_q;

endmodule

// File: tb/tb_mulpop_sched.sv
// Self-checking bench for mulpop_sched: directed and randomized jobs checked
// against a round-robin / arithmetic reference model.
module tb_mulpop_sched;

  localparam int NREQ = 4;
  localparam int OPW  = 24;
  localparam int TMO  = 16;

  logic        clk;
  logic        n_reset;
  logic        busy;
  logic [15:0] job_count;

  mulpop_sched_if #(.NREQ(NREQ), .OPW(OPW)) bus ();

  mulpop_sched #(.NREQ(NREQ), .OPW(OPW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .bus       (bus.master),
    .busy      (busy),
    .job_count (job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ptr  = 0;
  int exp_jobs = 0;

  // Datapath model controls, written only by the main sequence
  int dp_lat    = 3;
  bit dp_mute   = 1'b0;
  int stray_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First requester at or after ptr, searching upward with wrap
  function automatic int model_pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Datapath model: answers dp_start after dp_lat cycles, or never when muted
  initial begin
    int          pend;
    int          stray_served;
    logic [23:0] m_a1, m_a2;
    logic [47:0] prod;
    pend = 0;
    stray_served = 0;
    bus.dp_done = 1'b0;
    bus.dp_w    = '0;
    bus.dp_ones = '0;
    bus.dp_ovf  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.dp_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          prod        = 48'(m_a1) * 48'(m_a2);
          bus.dp_w    = prod[31:0];
          bus.dp_ones = 6'($countones(prod[31:0]));
          bus.dp_ovf  = |prod[47:32];
          bus.dp_done = 1'b1;
        end
      end
      if (bus.dp_start && !dp_mute) begin
        pend = dp_lat;
        m_a1 = bus.dp_a1;
        m_a2 = bus.dp_a2;
      end
      if (stray_cnt != stray_served) begin
        bus.dp_w    = 32'hFFFF_FFFF;
        bus.dp_ones = 6'd32;
        bus.dp_ovf  = 1'b1;
        bus.dp_done = 1'b1;
        stray_served = stray_cnt;
      end
    end
  end

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({pfx, "_dp_start"},  32'(bus.dp_start),  32'd0);
    check({pfx, "_dp_a1"},     32'(bus.dp_a1),     32'd0);
    check({pfx, "_dp_a2"},     32'(bus.dp_a2),     32'd0);
    check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({pfx, "_rsp_id"},    32'(bus.rsp_id),    32'd0);
    check({pfx, "_rsp_w"},     bus.rsp_w,          32'd0);
    check({pfx, "_rsp_ones"},  32'(bus.rsp_ones),  32'd0);
    check({pfx, "_rsp_ovf"},   32'(bus.rsp_ovf),   32'd0);
    check({pfx, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    check({pfx, "_busy"},      32'(busy),          32'd0);
    check({pfx, "_job_count"}, 32'(job_count),     32'd0);
  endtask

  // One complete job: grant, issue, wait, optional backpressure, handshake
  task automatic run_job(input logic [3:0] valid, input logic [95:0] a1s, input logic [95:0] a2s,
                         input int lat, input int bp, input bit mute);
    int          win, n;
    logic [23:0] ea1, ea2;
    logic [47:0] prod;
    logic [31:0] ew;
    logic [5:0]  eo;
    logic        ev, ee;
    @(negedge clk);
    bus.req_valid = valid;
    bus.req_a1    = a1s;
    bus.req_a2    = a2s;
    dp_lat        = lat;
    dp_mute       = mute;
    #1;
    win = model_pick(valid, exp_ptr);
    ea1 = a1s[win*OPW +: OPW];
    ea2 = a2s[win*OPW +: OPW];
    check("grant", 32'(bus.req_ready), 32'(1 << win));
    @(posedge clk);
    #1;
    check("dp_start",        32'(bus.dp_start),  32'd1);
    check("req_ready_issue", 32'(bus.req_ready), 32'd0);
    check("busy_issue",      32'(busy),          32'd1);
    check("dp_a1",           32'(bus.dp_a1),     32'(ea1));
    check("dp_a2",           32'(bus.dp_a2),     32'(ea2));
    check("rsp_id_latch",    32'(bus.rsp_id),    32'(win));
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rsp_latency", 32'(n), mute ? 32'(TMO) : 32'(lat + 1));
    if (mute) begin
      ew = '0; eo = '0; ev = 1'b0; ee = 1'b1;
    end else begin
      prod = 48'(ea1) * 48'(ea2);
      ew   = prod[31:0];
      eo   = 6'($countones(ew));
      ev   = |prod[47:32];
      ee   = 1'b0;
    end
    check("rsp_id",   32'(bus.rsp_id),   32'(win));
    check("rsp_w",    bus.rsp_w,         ew);
    check("rsp_ones", 32'(bus.rsp_ones), 32'(eo));
    check("rsp_ovf",  32'(bus.rsp_ovf),  32'(ev));
    check("rsp_err",  32'(bus.rsp_err),  32'(ee));
    for (int b = 0; b < bp; b++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_fields", {bus.rsp_w[23:0], 2'(bus.rsp_id), bus.rsp_ones},
            {ew[23:0], 2'(win), eo});
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    exp_jobs = (exp_jobs + 1) & 16'hFFFF;
    exp_ptr  = (win + 1) % NREQ;
    check("rsp_drop",  32'(bus.rsp_valid), 32'd0);
    check("job_count", 32'(job_count),     32'(exp_jobs));
    check("busy_idle", 32'(busy),          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_reset       = 1'b0;
    bus.req_valid = '0;
    bus.req_a1    = '0;
    bus.req_a2    = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #2;
    n_reset = 1'b1;

    // Single job from requester 1: 3*5
    run_job(4'b0010, 96'(3) << 24, 96'(5) << 24, 3, 0, 1'b0);
    // Overflowing product from requester 0
    run_job(4'b0001, 96'h00FF_FFFF, 96'h00FF_FFFF, 2, 0, 1'b0);

    // Fairness: all requesters, then only 0 and 2
    for (int k = 0; k < 5; k++)
      run_job(4'hF, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 2, 0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_job(4'b0101, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1, 0, 1'b0);

    // Backpressure with every requester pending, then immediate re-grant
    run_job(4'hF, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 2, 5, 1'b0);
    run_job(4'hF, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1, 0, 1'b0);

    // Randomized jobs
    for (int k = 0; k < 12; k++)
      run_job(4'($urandom_range(1, 15)), {$urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom}, int'($urandom_range(1, 4)),
              int'($urandom_range(0, 2)), 1'b0);

    // Timeout from requester 1, then a stray completion while idle
    run_job(4'b0010, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1, 0, 1'b1);
    bus.req_valid = '0;
    stray_cnt++;
    repeat (4) @(posedge clk);
    #1;
    check("stray_busy",      32'(busy),          32'd0);
    check("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("stray_dp_start",  32'(bus.dp_start),  32'd0);
    check("stray_job_count", 32'(job_count),     32'(exp_jobs));

    // Asynchronous reset while waiting on the datapath
    @(negedge clk);
    bus.req_valid = 4'b1001;
    bus.req_a1    = {4{24'h123456}};
    bus.req_a2    = {4{24'h654321}};
    dp_mute       = 1'b1;
    #1;
    w = model_pick(4'b1001, exp_ptr);
    check("pre_reset_grant", 32'(bus.req_ready), 32'(1 << w));
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_ptr  = 0;
    exp_jobs = 0;
    @(posedge clk);
    #2;
    n_reset = 1'b1;
    run_job(4'b1001, {4{24'h123456}}, {4{24'h654321}}, 2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mulpop_sched.md
# mulpop_sched

Round-robin scheduler that shares one multiply/popcount datapath (24x24 multiply, 32-bit low word W, set-bit count L, overflow flag) among NREQ requesters. Each accepted job's operands are issued to the datapath and held; the scheduler waits for completion or timeout and returns a tagged result on a single shared response channel. It sits between the bus-side requesters and the datapath. It also exports a completed-job counter for the GPIO output path.

## Interface
- NREQ, 4, number of requesters (2..8)
- OPW, 24, operand width
- TIMEOUT, 64, maximum cycles to wait for dp_done before aborting a job
- clk  in  1  clock, all logic on rising edge
- n_reset  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester job request
- req_a1  in  NREQ*OPW  packed first operands; requester i at [i*OPW +: OPW]
- req_a2  in  NREQ*OPW  packed second operands
- req_ready  out  NREQ  one-hot accept strobe
- dp_start  out  1  single-cycle datapath start
- dp_a1, dp_a2  out  OPW  operands to datapath; held stable from dp_start until job end
- dp_done  in  1  datapath completion pulse
- dp_w  in  32  product low word
- dp_ones  in  6  set-bit count of dp_w (0..32)
- dp_ovf  in  1  product bits [47:32] nonzero
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_id  out  3  index of the requester that owns the response
- rsp_w  out  32, rsp_ones  out  6, rsp_ovf  out  1  result fields
- rsp_err  out  1  job aborted by timeout
- busy  out  1  high in every state except IDLE
- job_count  out  16  completed responses (wraps at 0xFFFF -> 0)

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, the winner is the first set bit at or after rr_ptr, searching upward with wrap. Assert req_ready[winner] for that cycle only. Latch the winner's operands and winner index into rsp_id, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: dp_start=1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
- WAIT: on dp_done, capture dp_w/dp_ones/dp_ovf, set rsp_err=0, go to RESP. Otherwise increment the timeout counter. When the counter reaches TIMEOUT-1 with no dp_done, load rsp_w=0, rsp_ones=0, rsp_ovf=0, rsp_err=1 and go to RESP.
- RESP: rsp_valid=1 and all rsp_* fields hold stable until rsp_ready. On the handshake cycle, set rr_ptr = (rsp_id+1) mod NREQ, increment job_count, and go to IDLE.
- Timed-out jobs also increment job_count.
- dp_done outside WAIT is ignored.
- Only one job is in flight. req_ready is 0 in every state other than IDLE.
- A requester whose req_valid drops before acceptance is simply not selected. No request state is kept per requester.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0
  - req_ready=0, dp_start=0, dp_a1=dp_a2=0
  - rsp_valid=0, rsp_id=0, rsp_w=0, rsp_ones=0, rsp_ovf=0, rsp_err=0
  - busy=0, job_count=0
- Accept in cycle t (IDLE). dp_start in t+1. Earliest dp_done in t+2. rsp_valid from t+3.
- Earliest re-accept is the cycle after the rsp handshake. Minimum job period is 4 cycles plus datapath latency.
- Timeout: rsp_valid rises TIMEOUT cycles after dp_start when no dp_done arrives.
- Outputs are registered, except req_ready, which is combinational from state, rr_ptr and req_valid.
- Reset mid-job: the job is dropped, dp_start is deasserted immediately, and no response is produced. A late dp_done after reset is ignored because state is IDLE.
- dp_done and timeout in the same WAIT cycle: dp_done wins, rsp_err=0.

## Structure
- Shared package mulpop_pkg:
  - state enum
  - OPW, result width (32), ones width (6) and id width (3) constants
  - datapath register addresses shared with the GPIO bus decoder: A1 0x380, A2 0x388, W 0x390, L 0x398, CTRL/STATUS 0x3A0
- Sub-module rr_pick, purely combinational: inputs req (NREQ) and ptr; outputs one-hot grant and grant index. Instantiated once.

## Test plan
- Single job: requester 1 sends a1=3, a2=5; model returns dp_w=15, dp_ones=4 after 3 cycles -> req_ready[1] for one cycle; rsp_id=1, rsp_w=0x0000000F, rsp_ones=4, rsp_ovf=0, rsp_err=0; job_count=1.
- Overflow: a1=a2=0xFFFFFF -> model dp_w=0xFE000001, dp_ones=8, dp_ovf=1 -> response carries identical values.
- Fairness: all four req_valid held high from reset -> grant order 0,1,2,3,0. Then only requesters 0 and 2 held high -> order alternates 2,0,2,0.
- Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready stays 0 despite pending requests; after the handshake, the next grant follows one cycle later.
- Timeout: TIMEOUT=16, model never pulses dp_done -> rsp_err=1, rsp_w=0, rsp_valid 16 cycles after dp_start; a stray dp_done afterwards is ignored.
- Async reset asserted in WAIT -> all outputs return to reset values without a clock edge. After release, job_count=0 and the pending requester is granted fresh from rr_ptr=0.
